// File: rtl/rvfi_mem_responder_if.sv
// PicoRV32-style native memory bus between a core (master) and the responder (slave).
// The bus also carries the free stall request and the responder's status outputs.
interface rvfi_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        stall;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;
    logic [15:0] req_count;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, stall,
        input  mem_ready, mem_rdata, err, req_count
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, stall,
        output mem_ready, mem_rdata, err, req_count
    );
endinterface

// File: rtl/rvfi_mem_responder.sv
// Word-addressed memory responder for the PicoRV32 native bus with bounded stalls,
// a sticky protocol-violation flag and a saturating completed-transaction counter.
module rvfi_mem_responder #(
    parameter int unsigned WORDS     = 16,
    parameter int unsigned MAX_WAIT  = 3,
    parameter logic [31:0] INIT_WORD = 32'h0000_0013
) (
    input logic                 clock,
    input logic                 resetn,
    rvfi_mem_responder_if.slave bus
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  MW = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic [3:0]    w_wait_cnt_nxt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_instr;
    logic          r_ready;
    logic          w_ready_nxt;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic [15:0]   r_count;
    logic [15:0]   w_count_nxt;
    logic          w_latch;
    logic          w_mem_we;
    logic          w_mismatch;
    logic [AW-1:0] w_idx;
    logic [31:0]   r_mem [WORDS];

    // Higher address bits are dropped here, so addresses wrap modulo WORDS*4.
    assign w_idx      = r_addr[AW+1:2];
    assign w_mismatch = (bus.mem_addr != r_addr) || (bus.mem_wdata != r_wdata) ||
                        (bus.mem_wstrb != r_wstrb);

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
    assign bus.err       = r_err;
    assign bus.req_count = r_count;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ready_nxt    = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_err_nxt      = r_err;
        w_count_nxt    = r_count;
        w_latch        = 1'b0;
        w_mem_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    w_latch        = 1'b1;
                    w_wait_cnt_nxt = 4'd0;
                    w_state_nxt    = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!bus.mem_valid) begin
                    // Abandoned request: flag it and drop it without any side effect.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = r_err | w_mismatch;
                    if (bus.stall && (r_wait_cnt < MW)) begin
                        w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_ready_nxt = 1'b1;
                        w_count_nxt = (r_count == 16'hFFFF) ? r_count : (r_count + 16'd1);
                        if ((r_wstrb != 4'b0000) && !r_instr) begin
                            w_mem_we    = 1'b1;
                            w_rdata_nxt = 32'h0000_0000;
                        end else begin
                            // A fetch carrying strobes is served as a plain read.
                            w_err_nxt   = r_err | w_mismatch | (r_wstrb != 4'b0000);
                            w_rdata_nxt = r_mem[w_idx];
                        end
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= 4'd0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_wstrb    <= 4'b0000;
            r_instr    <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_count    <= 16'h0000;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_ready    <= w_ready_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_count    <= w_count_nxt;
            if (w_latch) begin
                r_addr  <= bus.mem_addr;
                r_wdata <= bus.mem_wdata;
                r_wstrb <= bus.mem_wstrb;
                r_instr <= bus.mem_instr;
            end else begin
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
                r_instr <= r_instr;
            end
        end
    end

    // Memory array with per-byte-lane writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                r_mem[i] <= INIT_WORD;
            end
        end else if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Scoreboard bench: a driver pushes expected responses from a plain array model of the
// memory; an independent monitor checks every mem_ready pulse against the queue.
module tb_rvfi_mem_responder;
    localparam int          WORDS    = 16;
    localparam int          MAX_WAIT = 3;
    localparam logic [31:0] INIT     = 32'h0000_0013;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        int          cnt;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   nvec   = 0;
    int   nfail  = 0;
    int   model_cnt = 0;
    bit   exp_err   = 1'b0;
    logic [31:0] ref_mem [WORDS];
    exp_t exp_q [$];

    rvfi_mem_responder_if bus();

    rvfi_mem_responder #(
        .WORDS(WORDS), .MAX_WAIT(MAX_WAIT), .INIT_WORD(INIT)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL spurious_ready: got mem_ready=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check32("rdata", bus.mem_rdata, e.rdata);
                check32("latency", 32'(cyc), 32'(e.cyc));
                check32("req_count", {16'h0, bus.req_count}, 32'(e.cnt));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = INIT;
        model_cnt = 0;
        exp_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn        = 1'b0;
        bus.mem_valid = 1'b0;
        bus.stall     = 1'b0;
        #1;
        check32("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        check32("rst_rdata", bus.mem_rdata, 32'h0);
        check32("rst_err", {31'h0, bus.err}, 32'h0);
        check32("rst_count", {16'h0, bus.req_count}, 32'h0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // One request: k cycles of stall requested, optional bus perturbation or valid drop.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input logic instr, input int k, input bit perturb, input bit drop);
        exp_t        e;
        int          idx;
        int          s;
        logic [31:0] w;
        bit          done;
        idx = int'((addr >> 2) % WORDS);
        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = strb;
        bus.stall     = 1'b0;
        if (drop) begin
            exp_err = 1'b1;
        end else begin
            s = (k < MAX_WAIT) ? k : MAX_WAIT;
            if (strb != 4'b0000 && !instr) begin
                w = ref_mem[idx];
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[idx] = w;
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_mem[idx];
                if (strb != 4'b0000) exp_err = 1'b1;
            end
            if (perturb) exp_err = 1'b1;
            if (model_cnt < 65535) model_cnt++;
            e.cnt = model_cnt;
            e.cyc = cyc + 2 + s;
            exp_q.push_back(e);
        end
        done = 1'b0;
        for (int j = 1; j <= 20 && !done; j++) begin
            @(negedge clock);
            if (drop) begin
                bus.mem_valid = 1'b0;
                done = 1'b1;
            end else if (bus.mem_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                bus.stall = (j <= k);
                if (perturb && j == 1) begin
                    bus.mem_addr  = addr ^ 32'h0000_0004;
                    bus.mem_wdata = ~wdata;
                end
            end
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL timeout: got no mem_ready, expected one for addr %h", addr);
        end
        bus.mem_valid = 1'b0;
        bus.stall     = 1'b0;
        repeat (drop ? 3 : 1) @(negedge clock);
        check32("err", {31'h0, bus.err}, {31'h0, exp_err});
        if (drop) check32("drop_count", {16'h0, bus.req_count}, 32'(model_cnt));
    endtask

    initial begin
        logic [3:0] strb;
        logic       instr;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'b0000;
        bus.stall     = 1'b0;
        model_reset();
        do_reset();

        txn(32'h0000_0008, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        txn(32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 1'b0, 1, 1'b0, 1'b0);
        txn(32'h0000_0004, 32'h0, 4'b0000, 1'b0, 2, 1'b0, 1'b0);
        txn(32'h0000_0000, 32'h0, 4'b0000, 1'b1, 10, 1'b0, 1'b0);
        txn(32'h0000_0040, 32'h1234_5678, 4'b1111, 1'b0, 0, 1'b0, 1'b0);
        txn(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            strb  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            instr = (strb == 4'b0000) ? 1'($urandom_range(0, 1)) : 1'b0;
            txn($urandom, $urandom, strb, instr, $urandom_range(0, 5), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        txn(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 0, 1'b0, 1'b1);
        txn(32'h0000_0010, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        do_reset();
        @(negedge clock);
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0000_000C;
        bus.mem_wdata = 32'hCAFE_F00D;
        bus.mem_wstrb = 4'b1111;
        bus.stall     = 1'b1;
        @(negedge clock);
        do_reset();
        txn(32'h0000_000C, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        txn(32'h0000_0014, 32'h5555_5555, 4'b1111, 1'b1, 1, 1'b0, 1'b0);
        txn(32'h0000_0014, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        do_reset();
        txn(32'h0000_0018, 32'h0BAD_CAFE, 4'b1111, 1'b0, 2, 1'b1, 1'b0);
        txn(32'h0000_0018, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        txn(32'h0000_001C, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check32("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
